boot_sequencer: RTL and testbench



---
 rtl/boot_pkg.sv | 22 ++
 rtl/button_debouncer.sv | 58 +++++
 rtl/boot_sequencer.sv | 111 +++++++++++
 tb/tb_boot_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// ============================================================================
// Module : boot_pkg
// Brief  : Shared types and constants for the boot sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_pkg;

    localparam int c_ADDR_W         = 16;
    localparam int c_DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        HELD  = 2'd0,
        COPY  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } boot_state_e;

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module : button_debouncer
// Brief  : 2-flop synchronizer and saturating counter; one-cycle press pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic press_o,
    output logic held_o
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);

    logic               sync1_q;
    logic               sync2_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               press_q;
    logic               press_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != c_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Fires only on the cycle the counter first reaches the threshold.
        press_d = (cnt_d == c_CNT_MAX) && (cnt_q != c_CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;
    assign held_o  = sync2_q;

endmodule

`default_nettype wire

// File: rtl/boot_sequencer.sv
// ============================================================================
// Module : boot_sequencer
// Brief  : Debounces the reset button, copies ROM to RAM, then releases CPU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_sequencer
    import boot_pkg::*;
#(
    parameter int ROM_WORDS       = 256,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DATA_W          = c_DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_button,
    output logic [c_ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0]   rom_value,
    output logic [c_ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0]   ram_value,
    output logic                ram_we,
    output logic                cpu_reset,
    output logic                is_powered_on,
    output logic                flag_execute_from_ram
);

    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(ROM_WORDS - 1);

    boot_state_e         state_q;
    boot_state_e         state_d;
    logic [c_ADDR_W-1:0] rd_ptr_q;
    logic [c_ADDR_W-1:0] rd_ptr_d;
    logic [c_ADDR_W-1:0] wr_addr_q;
    logic [c_ADDR_W-1:0] wr_addr_d;
    logic                we_q;
    logic                we_d;
    logic                press;
    logic                held;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .button_i (reset_button),
        .press_o  (press),
        .held_o   (held)
    );

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_addr_d = wr_addr_q;
        we_d      = 1'b0;
        if (press) begin
            state_d   = HELD;
            rd_ptr_d  = '0;
            wr_addr_d = '0;
        end else begin
            case (state_q)
                HELD: begin
                    rd_ptr_d  = '0;
                    wr_addr_d = '0;
                    if (!held) begin
                        state_d = COPY;
                    end
                end
                COPY: begin
                    // The word read this cycle lands on the ROM output next cycle.
                    we_d      = 1'b1;
                    wr_addr_d = rd_ptr_q;
                    if (rd_ptr_q == c_LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
                DRAIN:   state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = HELD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HELD;
            rd_ptr_q  <= '0;
            wr_addr_q <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_addr_q <= wr_addr_d;
            we_q      <= we_d;
        end
    end

    // ROM data already arrives registered, so it is forwarded straight to RAM.
    assign rom_address           = rd_ptr_q;
    assign ram_address           = wr_addr_q;
    assign ram_we                = we_q;
    assign ram_value             = we_q ? rom_value : '0;
    assign cpu_reset             = (state_q != RUN);
    assign is_powered_on         = (state_q == RUN);
    assign flag_execute_from_ram = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_boot_sequencer.sv
// ============================================================================
// Module : tb_boot_sequencer
// Brief  : Directed self-checking bench with a RAM-write scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_boot_sequencer;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, btn_a, rst_b, btn_b;
    logic [15:0] rom_addr_a, ram_addr_a, rom_addr_b, ram_addr_b;
    logic [7:0]  rom_val_a, ram_val_a, rom_val_b, ram_val_b;
    logic        we_a, cpu_rst_a, pwr_a, xram_a;
    logic        we_b, cpu_rst_b, pwr_b, xram_b;

    logic [7:0] rom_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t exp_a[$];
    wr_t exp_b[$];

    boot_sequencer #(.ROM_WORDS(4), .DEBOUNCE_CYCLES(3), .DATA_W(8)) u_dut_a (
        .clk                   (clk),
        .reset                 (rst_a),
        .reset_button          (btn_a),
        .rom_address           (rom_addr_a),
        .rom_value             (rom_val_a),
        .ram_address           (ram_addr_a),
        .ram_value             (ram_val_a),
        .ram_we                (we_a),
        .cpu_reset             (cpu_rst_a),
        .is_powered_on         (pwr_a),
        .flag_execute_from_ram (xram_a)
    );

    boot_sequencer #(.ROM_WORDS(1), .DEBOUNCE_CYCLES(3), .DATA_W(8)) u_dut_b (
        .clk                   (clk),
        .reset                 (rst_b),
        .reset_button          (btn_b),
        .rom_address           (rom_addr_b),
        .rom_value             (rom_val_b),
        .ram_address           (ram_addr_b),
        .ram_value             (ram_val_b),
        .ram_we                (we_b),
        .cpu_reset             (cpu_rst_b),
        .is_powered_on         (pwr_b),
        .flag_execute_from_ram (xram_b)
    );

    // Synchronous ROMs: data valid one cycle after the address.
    always @(posedge clk) begin
        rom_val_a <= (rom_addr_a < 16'd4) ? rom_a[rom_addr_a[1:0]] : 8'hEE;
        rom_val_b <= (rom_addr_b == 16'd0) ? 8'h5A : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_we", 32'(we_a), 32'd0);
            end else begin
                wr_t w;
                w = exp_a.pop_front();
                check("a_wr_addr", 32'(ram_addr_a), 32'(w.addr));
                check("a_wr_data", 32'(ram_val_a), 32'(w.data));
            end
        end
        if (we_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_we", 32'(we_b), 32'd0);
            end else begin
                wr_t w;
                w = exp_b.pop_front();
                check("b_wr_addr", 32'(ram_addr_b), 32'(w.addr));
                check("b_wr_data", 32'(ram_val_b), 32'(w.data));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input int count);
        for (int i = 0; i < count; i++) begin
            wr_t w;
            w.addr = 16'(i);
            w.data = rom_a[i];
            exp_a.push_back(w);
        end
    endtask

    task automatic check_run_a(input string tag, input logic on);
        check({tag, "_cpu_reset"}, 32'(cpu_rst_a), 32'(!on));
        check({tag, "_powered"},   32'(pwr_a),     32'(on));
        check({tag, "_xram"},      32'(xram_a),    32'(on));
    endtask

    task automatic check_reset_a(input string tag);
        check_run_a(tag, 1'b0);
        check({tag, "_we"},       32'(we_a),       32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr_a), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr_a), 32'd0);
        check({tag, "_ram_val"},  32'(ram_val_a),  32'd0);
    endtask

    task automatic check_copy_done_a(input string tag);
        step(1);
        check({tag, "_c1_we"},   32'(we_a),       32'd1);
        check({tag, "_c1_addr"}, 32'(ram_addr_a), 32'd0);
        step(4);
        check_run_a({tag, "_c5"}, 1'b1);
        check({tag, "_c5_we"}, 32'(we_a), 32'd0);
        check({tag, "_queue"}, 32'(exp_a.size()), 32'd0);
    endtask

    initial begin
        wr_t wb;
        rst_a = 1'b1; rst_b = 1'b1; btn_a = 1'b0; btn_b = 1'b0;
        step(3);
        check_reset_a("por");
        check("b_por_cpu_reset", 32'(cpu_rst_b), 32'd1);
        check("b_por_we",        32'(we_b),      32'd0);

        // Power-on copy
        push_a(4);
        wb.addr = 16'd0; wb.data = 8'h5A;
        exp_b.push_back(wb);
        rst_a = 1'b0; rst_b = 1'b0;
        step(1);
        check("c0_we",       32'(we_a),       32'd0);
        check("c0_rom_addr", 32'(rom_addr_a), 32'd0);
        check_run_a("c0", 1'b0);
        step(1);
        check("c1_we",     32'(we_a),       32'd1);
        check("c1_addr",   32'(ram_addr_a), 32'd0);
        check("b_c1_we",   32'(we_b),       32'd1);
        check("b_c1_data", 32'(ram_val_b),  32'h5A);
        step(1);
        check("b_c2_powered", 32'(pwr_b),     32'd1);
        check("b_c2_cpu_rst", 32'(cpu_rst_b), 32'd0);
        check("b_c2_xram",    32'(xram_b),    32'd1);
        check("b_c2_we",      32'(we_b),      32'd0);
        check_run_a("c2", 1'b0);
        step(2);
        check("c4_we",   32'(we_a),       32'd1);
        check("c4_addr", 32'(ram_addr_a), 32'd3);
        check_run_a("c4", 1'b0);
        step(1);
        check_run_a("c5", 1'b1);
        check("c5_we",    32'(we_a),         32'd0);
        check("c5_queue", 32'(exp_a.size()), 32'd0);

        // Glitch shorter than the debounce window
        btn_a = 1'b1;
        step(2);
        btn_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check_run_a("glitch", 1'b1);
        end

        // Press while running, hold 10 cycles, release
        btn_a = 1'b1;
        step(5);
        check_run_a("press_t5", 1'b1);
        step(1);
        check_run_a("press_t6", 1'b0);
        step(4);
        check_run_a("press_t10", 1'b0);
        push_a(4);
        btn_a = 1'b0;
        step(3);
        check_run_a("rel_c0", 1'b0);
        check("rel_c0_we", 32'(we_a), 32'd0);
        check_copy_done_a("rel");

        // Abort mid-copy: press debounced while ram_address is 2
        btn_a = 1'b1;
        step(6);
        check_run_a("abort_held", 1'b0);
        btn_a = 1'b0;
        step(1);
        btn_a = 1'b1;
        push_a(3);
        step(2);
        check("abort_c0_we", 32'(we_a), 32'd0);
        step(3);
        check("abort_c3_we",   32'(we_a),       32'd1);
        check("abort_c3_addr", 32'(ram_addr_a), 32'd2);
        step(1);
        check("abort_c4_we", 32'(we_a), 32'd0);
        check_run_a("abort_c4", 1'b0);
        step(4);
        check("abort_hold_we", 32'(we_a), 32'd0);
        check("abort_queue", 32'(exp_a.size()), 32'd0);
        push_a(4);
        btn_a = 1'b0;
        step(3);
        check_copy_done_a("abort_rel");

        // Synchronous reset during COPY with button high
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        push_a(2);
        step(3);
        rst_a = 1'b1;
        btn_a = 1'b1;
        step(1);
        check_reset_a("rst_copy");
        step(3);
        check_reset_a("rst_hold");
        btn_a = 1'b0;
        step(1);
        push_a(4);
        rst_a = 1'b0;
        step(1);
        check_copy_done_a("rst_rel");

        // Press lands in DRAIN: RUN must not be entered
        rst_a = 1'b1;
        btn_a = 1'b1;
        step(2);
        push_a(4);
        rst_a = 1'b0;
        step(5);
        check("drain_c4_we",   32'(we_a),       32'd1);
        check("drain_c4_addr", 32'(ram_addr_a), 32'd3);
        step(1);
        check_run_a("drain_c5", 1'b0);
        check("drain_c5_we", 32'(we_a), 32'd0);
        step(3);
        check_run_a("drain_hold", 1'b0);
        push_a(4);
        btn_a = 1'b0;
        step(3);
        check_copy_done_a("drain_rel");

        check("b_final_powered", 32'(pwr_b),        32'd1);
        check("b_final_queue",   32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
